umul_bi_nch: RTL and testbench

NCH-channel bipolar unary multiplier with a managed stream window.
- Each channel multiplies its bipolar input bitstream iA[ch] by a buffered binary weight. It uses per-channel low-discrepancy sequence generators that are gated by the input bit.
- Weights arrive through a valid/ready load port. A start command runs one full stream window of 2^BITWIDTH enabled cycles.
- Sits between the SC stream sources and the scaler/adder stages of the SFFT datapath.

---
 rtl/umul_bi_nch_if.sv | 27 ++
 rtl/umul_bi_nch.sv | 164 ++++++++++++++++
 tb/tb_umul_bi_nch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/umul_bi_nch_if.sv
// Load-port and stream signals of the NCH-channel bipolar unary multiplier.
// master drives weights, start and input streams; slave is the multiplier.
interface umul_bi_nch_if #(
   parameter int BITWIDTH = 8,
   parameter int NCH      = 4
);
   logic [BITWIDTH-1:0] iB;
   logic                iLdValid;
   logic                oLdReady;
   logic                iStart;
   logic [NCH-1:0]      iA;
   logic [NCH-1:0]      oMult;
   logic [NCH-1:0]      oB;
   logic                oValid;
   logic                oBusy;
   logic                oDone;

   modport master (
      output iB, iLdValid, iStart, iA,
      input  oLdReady, oMult, oB, oValid, oBusy, oDone
   );

   modport slave (
      input  iB, iLdValid, iStart, iA,
      output oLdReady, oMult, oB, oValid, oBusy, oDone
   );
endinterface

// File: rtl/umul_bi_nch.sv
// NCH-channel bipolar unary multiplier over a 2^BITWIDTH-cycle stream window.
// Define UMUL_BI_ACC_EN to add oAcc, the per-channel count of oMult ones.
module umul_bi_lane #(
   parameter int BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iClr,
   input  logic                iCntClr,
   input  logic                iAdv,
   input  logic                iA,
   input  logic [BITWIDTH-1:0] iW,
   input  logic [BITWIDTH-1:0] iSR,
`ifdef UMUL_BI_ACC_EN
   input  logic                iVld,
   output logic [BITWIDTH:0]   oAcc,
`endif
   output logic                oMult,
   output logic                oB
);
   logic [BITWIDTH-1:0] topCnt, botCnt;

   function automatic logic [BITWIDTH-1:0] bitRev(input logic [BITWIDTH-1:0] v);
      logic [BITWIDTH-1:0] r;
      for (int i = 0; i < BITWIDTH; i++) r[i] = v[BITWIDTH-1-i];
      return r;
   endfunction

   // The input bit picks which sequence advances: bot for a 1, top for a 0.
   always_ff @(posedge iClk) begin
      if (iRst || iClr) begin
         topCnt <= '0;
         botCnt <= '0;
         oMult  <= 1'b0;
         oB     <= 1'b0;
      end else if (iCntClr) begin
         topCnt <= '0;
         botCnt <= '0;
      end else if (iAdv) begin
         oMult <= iA ? (iW > bitRev(botCnt)) : !(iW > bitRev(topCnt));
         oB    <= iW > iSR;
         if (iA) botCnt <= botCnt + 1'b1;
         else    topCnt <= topCnt + 1'b1;
      end
   end

`ifdef UMUL_BI_ACC_EN
   always_ff @(posedge iClk) begin
      if (iRst || iClr || iCntClr) oAcc <= '0;
      else if (iVld && oMult)      oAcc <= oAcc + 1'b1;
   end
`endif
endmodule

module umul_bi_nch #(
   parameter int BITWIDTH = 8,
   parameter int NCH      = 4
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEn,
   input  logic iClr,
`ifdef UMUL_BI_ACC_EN
   output logic [NCH*(BITWIDTH+1)-1:0] oAcc,
`endif
   umul_bi_nch_if.slave bus
);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                         state;
   logic [NCH-1:0][BITWIDTH-1:0]   wBuf;
   logic [PW-1:0]                  ldPtr;
   logic                           loaded;
   logic [BITWIDTH-1:0]            winCnt, sR;
   logic                           valid, done, startGo, adv;
   logic [NCH-1:0]                 mult, bBits;

   // A pending load wins over start; start is retried on a later cycle.
   assign startGo = (state == IDLE) && !iClr && !bus.iLdValid && bus.iStart && loaded;
   assign adv     = (state == RUN) && iEn && !iClr;

   always_comb begin
      sR = '0;
      for (int i = 0; i < BITWIDTH; i++) sR[i] = winCnt[BITWIDTH-1-i];
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state  <= IDLE;
         wBuf   <= '0;
         ldPtr  <= '0;
         loaded <= 1'b0;
         winCnt <= '0;
         valid  <= 1'b0;
         done   <= 1'b0;
      end else if (iClr) begin
         state  <= IDLE;
         winCnt <= '0;
         valid  <= 1'b0;
         done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               valid <= 1'b0;
               done  <= 1'b0;
               if (bus.iLdValid) begin
                  wBuf[ldPtr] <= bus.iB;
                  if (ldPtr == PW'(NCH-1)) begin
                     ldPtr  <= '0;
                     loaded <= 1'b1;
                  end else begin
                     ldPtr <= ldPtr + 1'b1;
                  end
               end else if (startGo) begin
                  state  <= RUN;
                  winCnt <= '0;
               end
            end
            RUN: begin
               done  <= 1'b0;
               valid <= iEn;
               if (iEn) begin
                  winCnt <= winCnt + 1'b1;
                  if (winCnt == '1) state <= DONE;
               end
            end
            DONE: begin
               valid <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : gLane
      umul_bi_lane #(.BITWIDTH(BITWIDTH)) uLane (
         .iClk    (iClk),
         .iRst    (iRst),
         .iClr    (iClr),
         .iCntClr (startGo),
         .iAdv    (adv),
         .iA      (bus.iA[g]),
         .iW      (wBuf[g]),
         .iSR     (sR),
`ifdef UMUL_BI_ACC_EN
         .iVld    (valid),
         .oAcc    (oAcc[g*(BITWIDTH+1) +: BITWIDTH+1]),
`endif
         .oMult   (mult[g]),
         .oB      (bBits[g])
      );
   end

   assign bus.oLdReady = (state == IDLE);
   assign bus.oBusy    = (state == RUN);
   assign bus.oValid   = valid;
   assign bus.oDone    = done;
   assign bus.oMult    = mult;
   assign bus.oB       = bBits;
endmodule

// File: tb/tb_umul_bi_nch.sv
// Randomized and directed bench for umul_bi_nch against a cycle model of the
// window rules, plus hand-computed window ones counts.
module tb_umul_bi_nch;
   localparam int BW  = 8;
   localparam int NCH = 4;
   localparam int W   = 1 << BW;

   logic iClk = 1'b0;
   logic iRst, iEn, iClr;
   umul_bi_nch_if #(.BITWIDTH(BW), .NCH(NCH)) bus ();
`ifdef UMUL_BI_ACC_EN
   logic [NCH*(BW+1)-1:0] oAcc;
`endif

   umul_bi_nch #(.BITWIDTH(BW), .NCH(NCH)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .iEn  (iEn),
      .iClr (iClr),
`ifdef UMUL_BI_ACC_EN
      .oAcc (oAcc),
`endif
      .bus  (bus)
   );

   always #5 iClk = ~iClk;

   int errCnt = 0;
   int chkCnt = 0;
   bit chkOn  = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int rev(input int v);
      int r = 0;
      for (int i = 0; i < BW; i++) if (v[i]) r |= 1 << (BW-1-i);
      return r;
   endfunction

   // Behavioural model: mode 0 idle, 1 streaming, 2 window end.
   int mMode, mPtr, mWin;
   bit mLoaded;
   int mW[NCH], mTop[NCH], mBot[NCH], mAcc[NCH];
   bit [NCH-1:0] eMult, eB;
   bit eValid, eDone;

   always @(posedge iClk) begin
      if (iRst) begin
         mMode <= 0; mLoaded <= 0; mPtr <= 0; mWin <= 0;
         eMult <= '0; eB <= '0; eValid <= 0; eDone <= 0;
         for (int c = 0; c < NCH; c++) begin
            mW[c] <= 0; mTop[c] <= 0; mBot[c] <= 0; mAcc[c] <= 0;
         end
      end else if (iClr) begin
         mMode <= 0; mWin <= 0; eMult <= '0; eB <= '0; eValid <= 0; eDone <= 0;
         for (int c = 0; c < NCH; c++) begin
            mTop[c] <= 0; mBot[c] <= 0; mAcc[c] <= 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) if (eValid && eMult[c]) mAcc[c] <= mAcc[c] + 1;
         case (mMode)
            0: begin
               eValid <= 0; eDone <= 0;
               if (bus.iLdValid) begin
                  mW[mPtr] <= int'(bus.iB);
                  if (mPtr == NCH-1) begin mPtr <= 0; mLoaded <= 1; end
                  else mPtr <= mPtr + 1;
               end else if (bus.iStart && mLoaded) begin
                  mMode <= 1; mWin <= 0;
                  for (int c = 0; c < NCH; c++) begin
                     mTop[c] <= 0; mBot[c] <= 0; mAcc[c] <= 0;
                  end
               end
            end
            1: begin
               eDone <= 0;
               eValid <= iEn;
               if (iEn) begin
                  for (int c = 0; c < NCH; c++) begin
                     if (bus.iA[c]) begin
                        eMult[c] <= mW[c] > rev(mBot[c]);
                        mBot[c]  <= (mBot[c] + 1) % W;
                     end else begin
                        eMult[c] <= !(mW[c] > rev(mTop[c]));
                        mTop[c]  <= (mTop[c] + 1) % W;
                     end
                     eB[c] <= mW[c] > rev(mWin);
                  end
                  mWin <= (mWin + 1) % W;
                  if (mWin == W-1) mMode <= 2;
               end
            end
            default: begin eValid <= 0; eDone <= 1; mMode <= 0; end
         endcase
      end
   end

   int onesM[NCH], onesB[NCH];
   int vCnt, capIdx;
   logic [NCH-1:0] cap[W];
   logic [NCH-1:0] ref100[100];

   always @(negedge iClk) begin
      if (chkOn) begin
         chk("oMult", 64'(bus.oMult), 64'(eMult));
         chk("oB", 64'(bus.oB), 64'(eB));
         chk("oValid", 64'(bus.oValid), 64'(eValid));
         chk("oDone", 64'(bus.oDone), 64'(eDone));
         chk("oBusy", 64'(bus.oBusy), 64'(mMode == 1));
         chk("oLdReady", 64'(bus.oLdReady), 64'(mMode == 0));
`ifdef UMUL_BI_ACC_EN
         for (int c = 0; c < NCH; c++)
            chk("oAcc", 64'(oAcc[c*(BW+1) +: BW+1]), 64'(mAcc[c]));
`endif
         if (bus.oValid) begin
            for (int c = 0; c < NCH; c++) begin
               onesM[c] += int'(bus.oMult[c]);
               onesB[c] += int'(bus.oB[c]);
            end
            if (capIdx < W) cap[capIdx] = bus.oMult;
            capIdx++;
            vCnt++;
         end
      end
   end

   task automatic clrTally();
      for (int c = 0; c < NCH; c++) begin onesM[c] = 0; onesB[c] = 0; end
      vCnt = 0; capIdx = 0;
   endtask

   task automatic loadW(input int w0, input int w1, input int w2, input int w3, input bit withStart);
      int ws[NCH];
      ws = '{w0, w1, w2, w3};
      for (int c = 0; c < NCH; c++) begin
         bus.iLdValid = 1'b1;
         bus.iB       = BW'(ws[c]);
         bus.iStart   = withStart && (c == NCH-1);
         @(negedge iClk);
      end
      bus.iLdValid = 1'b0;
      bus.iStart   = 1'b0;
   endtask

   task automatic startWin();
      bus.iStart = 1'b1;
      @(negedge iClk);
      bus.iStart = 1'b0;
   endtask

   // enMode: 0 always enabled, 1 alternating, 2 random. Stops at oDone or after a clear.
   task automatic runWin(input bit rndA, input logic [NCH-1:0] aPat, input int enMode,
                         input bit ldNoise, input int clrPer);
      bit tog = 1'b1;
      bit clrNow;
      int n = 0;
      while (n < 3000) begin
         bus.iA       = rndA ? NCH'($urandom) : aPat;
         iEn          = (enMode == 0) ? 1'b1 : (enMode == 1) ? tog : ($urandom_range(3) != 0);
         tog          = ~tog;
         bus.iLdValid = ldNoise ? 1'($urandom_range(1)) : 1'b0;
         bus.iB       = BW'($urandom);
         clrNow       = (clrPer > 0) && ($urandom_range(clrPer-1) == 0);
         iClr         = clrNow;
         @(negedge iClk);
         n++;
         if (clrNow) break;
         if (bus.oDone) break;
      end
      iEn = 1'b0; iClr = 1'b0; bus.iLdValid = 1'b0;
      if (n >= 3000) begin
         errCnt++; chkCnt++;
         $display("FAIL windowTimeout: got no oDone within %0d cycles", n);
      end
   endtask

   task automatic checkCounts(input string tag, input int em[NCH], input int eb[NCH]);
      for (int c = 0; c < NCH; c++) begin
         chk({tag, "_multOnes"}, 64'(onesM[c]), 64'(em[c]));
         chk({tag, "_bOnes"}, 64'(onesB[c]), 64'(eb[c]));
      end
      chk({tag, "_validCnt"}, 64'(vCnt), 64'(W));
   endtask

   int expA1[NCH] = '{128, 255, 0, 64};
   int expA0[NCH] = '{128, 1, 256, 192};
   bit streamOk;

   initial begin
      iRst = 1'b1; iEn = 1'b0; iClr = 1'b0;
      bus.iB = '0; bus.iLdValid = 1'b0; bus.iStart = 1'b0; bus.iA = '0;
      clrTally();
      @(posedge iClk);
      #1 chkOn = 1'b1;
      repeat (2) @(negedge iClk);
      chk("rstLdReady", 64'(bus.oLdReady), 64'd1);
      chk("rstValid", 64'(bus.oValid), 64'd0);
      iRst = 1'b0;

      // Start with nothing loaded must be ignored.
      startWin();
      @(negedge iClk);
      chk("startUnloaded", 64'(bus.oBusy), 64'd0);

      // All ones on iA.
      loadW(8'h80, 8'hFF, 8'h00, 8'h40, 1'b0);
      clrTally();
      startWin();
      runWin(1'b0, 4'hF, 0, 1'b0, 0);
`ifdef UMUL_BI_ACC_EN
      chk("accAtDone", 64'(oAcc), 64'({9'd64, 9'd0, 9'd255, 9'd128}));
`endif
      checkCounts("a1", expA1, expA1);
      for (int i = 0; i < 100; i++) ref100[i] = cap[i];

      // All zeros on iA.
      clrTally();
      startWin();
      runWin(1'b0, 4'h0, 0, 1'b0, 0);
      checkCounts("a0", expA0, expA1);

      // Alternating enable; load attempts during RUN must not change weights.
      clrTally();
      startWin();
      runWin(1'b0, 4'hF, 1, 1'b1, 0);
      checkCounts("toggle", expA1, expA1);

      // Soft clear after 100 enabled cycles, then restart without reload.
      startWin();
      iEn = 1'b1; bus.iA = 4'hF;
      repeat (100) @(negedge iClk);
      iClr = 1'b1;
      @(negedge iClk);
      iClr = 1'b0; iEn = 1'b0;
      chk("clrLdReady", 64'(bus.oLdReady), 64'd1);
      chk("clrValid", 64'(bus.oValid), 64'd0);
      clrTally();
      startWin();
      runWin(1'b0, 4'hF, 0, 1'b0, 0);
      streamOk = 1'b1;
      for (int i = 0; i < 100; i++) if (cap[i] !== ref100[i]) streamOk = 1'b0;
      chk("restartStream", 64'(streamOk), 64'd1);
      checkCounts("restart", expA1, expA1);

      // Random weights, streams, enables, load noise and occasional clears.
      for (int k = 0; k < 8; k++) begin
         loadW(int'($urandom_range(W-1)), int'($urandom_range(W-1)),
               int'($urandom_range(W-1)), int'($urandom_range(W-1)), k[0]);
         startWin();
         runWin(1'b1, '0, 2, 1'b1, (k % 3 == 2) ? 400 : 0);
         repeat (2) @(negedge iClk);
      end

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule
